axis_frame_tx: RTL and testbench

//  AXI4-Stream transmitter: the master-side counterpart of the dataplane RX path.
//  - Buffers frames from the internal dataplane (s_* side) in a beat FIFO.
//  - Replays them on the external AXI-Stream master port (tvalid/tdata/tkeep/tlast/tready).
//  - Store-and-forward, with a cut-through fallback for oversize frames.
//  - Enforces a programmable inter-frame gap.

---
 rtl/axis_frame_tx.sv | 132 +++++++++++++
 tb/tb_axis_frame_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_tx.sv
// axis_frame_tx: buffers dataplane frames in a beat FIFO and replays them as an
// AXI4-Stream master (store-and-forward, cut-through when full, inter-frame gap). Option: TX_STATS_EN.
module axis_frame_tx #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IFG_CYCLES = 2,
  localparam int unsigned KEEP_W    = DATA_WIDTH / 8,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [KEEP_W-1:0]     s_keep,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  tx_enable,
  output logic                  tvalid,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic [KEEP_W-1:0]     tkeep,
  output logic                  tlast,
  input  logic                  tready,
  output logic                  busy,
  output logic [AW:0]           frames_pending,
  output logic [31:0]           frame_count,
  output logic [31:0]           byte_count
);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned BEAT_W = DATA_WIDTH + KEEP_W + 1;
  localparam int unsigned GW     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     gap_cnt, gap_cnt_nxt;
  logic [BEAT_W-1:0] mem [DEPTH];
  logic [BEAT_W-1:0] head;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              ready_q, empty, full, push, pop, start;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_ready = ready_q && !full;
  assign push    = s_valid && s_ready;
  assign pop     = tvalid && tready;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign busy    = (state != IDLE);
  // Full FIFO starts a frame even without a stored tlast (oversize frame cut-through).
  assign start   = tx_enable && ((frames_pending != '0) || full);

  // Holds s_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_last, s_keep, s_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frames_pending <= '0;
    else     frames_pending <= frames_pending + PW'(push && s_last) - PW'(pop && tlast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // The last gap cycle re-evaluates the start condition so the gap is exactly IFG_CYCLES idle cycles.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    tvalid      = 1'b0;
    tdata       = '0;
    tkeep       = '0;
    tlast       = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = SEND;
      SEND: begin
        tvalid = !empty;
        if (!empty) {tlast, tkeep, tdata} = head;
        if (!empty && tready && head[BEAT_W-1]) begin
          gap_cnt_nxt = '0;
          state_nxt   = (IFG_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt + GW'(1);
        if (gap_cnt == GW'(IFG_CYCLES - 1)) state_nxt = start ? SEND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TX_STATS_EN
  function automatic logic [31:0] ones(input logic [KEEP_W-1:0] k);
    ones = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) ones = ones + 32'(k[i]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
      byte_count  <= '0;
    end else if (pop) begin
      frame_count <= frame_count + 32'(tlast);
      byte_count  <= byte_count + ones(tkeep);
    end
  end
`else
  assign frame_count = '0;
  assign byte_count  = '0;
`endif

endmodule

// File: tb/tb_axis_frame_tx.sv
// tb_axis_frame_tx: directed + randomized bench for axis_frame_tx with a queue-based
// frame model (beat order, pending frames, stats, IFG, latency, AXIS hold rule).
module tb_axis_frame_tx;
  localparam int unsigned DW = 64, KW = 8, DEPTH = 16, IFG = 2;
`ifdef TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst, s_valid, s_last, s_ready, tx_enable, tvalid, tlast, tready, busy;
  logic [DW-1:0] s_data, tdata;
  logic [KW-1:0] s_keep, tkeep;
  logic [$clog2(DEPTH):0] frames_pending;
  logic [31:0] frame_count, byte_count;

  always #5 clk = ~clk;

  axis_frame_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep),
    .s_last(s_last), .s_ready(s_ready), .tx_enable(tx_enable), .tvalid(tvalid),
    .tdata(tdata), .tkeep(tkeep), .tlast(tlast), .tready(tready), .busy(busy),
    .frames_pending(frames_pending), .frame_count(frame_count), .byte_count(byte_count)
  );

  int    n_cmp = 0, n_err = 0;
  beat_t src_q[$], exp_q[$];
  int    cyc = 0, n_hs = 0, m_pending = 0;
  int    last_push_cyc = 0, first_valid_cyc = 0, tlast_cyc = 0, last_gap = 0;
  logic [31:0] m_frames = 0, m_bytes = 0;
  bit    gap_armed = 0, prev_valid = 0, prev_ready = 0, src_gaps = 0, rnd_ready = 0;
  beat_t prev_beat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int popc(input logic [KW-1:0] k);
    int n = 0;
    for (int i = 0; i < int'(KW); i++) n += int'(k[i]);
    return n;
  endfunction

  function automatic beat_t mk(input logic [KW-1:0] keep, input logic last);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.keep = keep;
    b.last = last;
    return b;
  endfunction

  task automatic drive_src();
    if (src_q.size() > 0 && (!src_gaps || $urandom_range(3, 0) != 0)) begin
      s_valid = 1'b1;
      s_data  = src_q[0].data;
      s_keep  = src_q[0].keep;
      s_last  = src_q[0].last;
    end else begin
      s_valid = 1'b0;
      s_data  = '0;
      s_keep  = '0;
      s_last  = 1'b0;
    end
    if (rnd_ready) tready = ($urandom_range(3, 0) != 0);
  endtask

  task automatic add_frame(input int len, input logic [KW-1:0] last_keep);
    for (int i = 0; i < len; i++)
      src_q.push_back(mk((i == len - 1) ? last_keep : {KW{1'b1}}, i == len - 1));
    drive_src();
  endtask

  // One clock: check outputs at the negedge, advance the model, then move inputs after the edge.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    check("pending", 64'(frames_pending), 64'(m_pending));
    check("frame_count", 64'(frame_count), 64'(STATS ? m_frames : 32'd0));
    check("byte_count", 64'(byte_count), 64'(STATS ? m_bytes : 32'd0));
    if (!tvalid) check("idle_zero", tdata | 64'({tkeep, tlast}), 64'(0));
    if (prev_valid && !prev_ready) begin
      check("hold_valid", 64'(tvalid), 64'(1));
      check("hold_data", tdata, prev_beat.data);
      check("hold_ctl", 64'({tkeep, tlast}), 64'({prev_beat.keep, prev_beat.last}));
    end
    if (tvalid && !prev_valid) begin
      first_valid_cyc = cyc;
      if (gap_armed) begin
        last_gap  = cyc - tlast_cyc - 1;
        gap_armed = 0;
        check("ifg_min", 64'(last_gap >= int'(IFG)), 64'(1));
      end
    end
    if (tvalid && tready) begin
      n_hs++;
      check("beat_available", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        check("beat_data", tdata, b.data);
        check("beat_ctl", 64'({tkeep, tlast}), 64'({b.keep, b.last}));
        m_bytes += 32'(popc(b.keep));
        if (b.last) begin
          m_frames++;
          m_pending--;
          tlast_cyc = cyc;
          gap_armed = 1;
        end
      end
    end
    if (s_valid && s_ready) begin
      b = src_q.pop_front();
      exp_q.push_back(b);
      if (b.last) begin
        m_pending++;
        last_push_cyc = cyc;
      end
    end
    prev_valid = tvalid;
    prev_ready = tready;
    prev_beat  = {tdata, tkeep, tlast};
    @(posedge clk);
    cyc++;
    #1;
    drive_src();
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int i = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || busy) && i < bound) begin
      tick();
      i++;
    end
    check(tag, 64'(src_q.size() + exp_q.size() + int'(busy)), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    rst = 1'b1; tx_enable = 1'b0; tready = 1'b0;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    #12;
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pending", 64'(frames_pending), 64'(0));
    check("rst_stats", 64'(frame_count | byte_count), 64'(0));
    check("rst_tdata", tdata | 64'({tkeep, tlast}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("post_rst_s_ready", 64'(s_ready), 64'(1));

    // 1: 3-beat frame, keep FF,FF,0F, latency 2 cycles, 20 bytes
    tx_enable = 1'b1; tready = 1'b1;
    h0 = n_hs;
    src_q.push_back(mk(8'hFF, 1'b0));
    src_q.push_back(mk(8'hFF, 1'b0));
    src_q.push_back(mk(8'h0F, 1'b1));
    drive_src();
    wait_idle("t1_drain", 40);
    check("t1_latency", 64'(first_valid_cyc - last_push_cyc), 64'(2));
    check("t1_beats", 64'(n_hs - h0), 64'(3));
    check("t1_bytes", 64'(byte_count), 64'(STATS ? 32'd20 : 32'd0));

    // 2: two 2-beat frames queued, exact IFG between them
    tx_enable = 1'b0;
    add_frame(2, 8'h3C);
    add_frame(2, 8'h01);
    for (int i = 0; i < 20 && src_q.size() != 0; i++) tick();
    check("t2_queued", 64'(frames_pending), 64'(2));
    tx_enable = 1'b1;
    wait_idle("t2_drain", 60);
    check("t2_gap", 64'(last_gap), 64'(IFG));
    check("t2_frames", 64'(frame_count), 64'(STATS ? 32'd3 : 32'd0));

    // 3: tready 1,0,0,1 mid-frame
    h0 = n_hs;
    add_frame(4, 8'h7F);
    for (int i = 0; i < 30 && n_hs == h0; i++) tick();
    check("t3_first_hs", 64'(n_hs - h0), 64'(1));
    tready = 1'b0;
    tick();
    tick();
    check("t3_stalled", 64'(tvalid), 64'(1));
    tready = 1'b1;
    wait_idle("t3_drain", 40);
    check("t3_beats", 64'(n_hs - h0), 64'(4));

    // 4: 20-beat frame, FIFO fills at 16, cut-through
    tready = 1'b0;
    h0 = n_hs;
    add_frame(20, 8'hFF);
    repeat (30) tick();
    check("t4_accepted", 64'(20 - src_q.size()), 64'(16));
    check("t4_s_ready", 64'(s_ready), 64'(0));
    check("t4_cut_through", 64'(tvalid), 64'(1));
    tready = 1'b1;
    wait_idle("t4_drain", 80);
    check("t4_beats", 64'(n_hs - h0), 64'(20));

    // 5: tx_enable low holds a pending frame
    tx_enable = 1'b0;
    h0 = n_hs;
    add_frame(3, 8'h0F);
    repeat (12) tick();
    check("t5_no_tx", 64'(n_hs - h0), 64'(0));
    check("t5_tvalid", 64'(tvalid), 64'(0));
    check("t5_pending", 64'(frames_pending), 64'(1));
    tx_enable = 1'b1;
    wait_idle("t5_drain", 40);
    check("t5_pending_done", 64'(frames_pending), 64'(0));

    // 6: reset during beat 2 of 4
    h0 = n_hs;
    add_frame(4, 8'hFF);
    for (int i = 0; i < 30 && n_hs == h0; i++) tick();
    check("t6_beat2_presented", 64'(tvalid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("t6_async_tvalid", 64'(tvalid), 64'(0));
    check("t6_async_busy", 64'(busy), 64'(0));
    exp_q.delete(); src_q.delete();
    m_pending = 0; m_frames = 0; m_bytes = 0;
    prev_valid = 0; gap_armed = 0;
    drive_src();
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("t6_s_ready", 64'(s_ready), 64'(1));
    check("t6_pending", 64'(frames_pending), 64'(0));
    check("t6_stats", 64'(frame_count | byte_count), 64'(0));

    // Randomized traffic with source gaps and random backpressure
    src_gaps = 1; rnd_ready = 1;
    for (int f = 0; f < 14; f++)
      add_frame(int'($urandom_range(6, 1)), 8'($urandom_range(255, 1)));
    wait_idle("rand_drain", 3000);
    rnd_ready = 0; tready = 1'b1;
    tick();
    check("rand_pending", 64'(frames_pending), 64'(0));
    check("rand_frames", 64'(frame_count), 64'(STATS ? 32'd14 : 32'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
